// File: rtl/store_write_buffer_if.sv
// Store-path bus bundle for store_write_buffer.
// slave  : the buffer side (takes store requests, drives the memory write port).
// master : the pipeline/memory side.
// Signals: store_valid/type/addr/data, store_accept, full, empty, count,
//          store_error, mem_wr_valid/addr/data/mask, mem_wr_ready.
// Optional (STORE_FWD_EN): fwd_addr, fwd_hit, fwd_data, fwd_mask.
interface store_write_buffer_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          store_valid;
  logic [2:0]    store_type;
  logic [31:0]   store_addr;
  logic [31:0]   store_data;
  logic          store_accept;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          store_error;
  logic          mem_wr_valid;
  logic [31:0]   mem_wr_addr;
  logic [31:0]   mem_wr_data;
  logic [3:0]    mem_wr_mask;
  logic          mem_wr_ready;
`ifdef STORE_FWD_EN
  logic [31:0]   fwd_addr;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic [3:0]    fwd_mask;
`endif

  modport slave (
    input  store_valid, store_type, store_addr, store_data, mem_wr_ready,
    output store_accept, full, empty, count, store_error,
    output mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_mask
`ifdef STORE_FWD_EN
    , input fwd_addr
    , output fwd_hit, fwd_data, fwd_mask
`endif
  );

  modport master (
    output store_valid, store_type, store_addr, store_data, mem_wr_ready,
    input  store_accept, full, empty, count, store_error,
    input  mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_mask
`ifdef STORE_FWD_EN
    , output fwd_addr
    , input fwd_hit, fwd_data, fwd_mask
`endif
  );
endinterface

// File: rtl/store_write_buffer.sv
// store_write_buffer: aligns memory-stage stores (sb/sh/sw) into
// {word address, replicated data, byte mask}, queues them in a DEPTH-entry
// FIFO and drains them in program order over a valid/ready write port.
// Ports: clk, rst_n (async active-low), bus (store_write_buffer_if.slave).
// Optional feature macro STORE_FWD_EN: combinational store-to-load byte
// forwarding from buffered entries (fwd_addr in; fwd_hit/fwd_data/fwd_mask out).
module store_write_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  store_write_buffer_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  mask;
  } entry_t;

  entry_t        entries [DEPTH];
  logic [AW-1:0] head_q;
  logic [AW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_next;
  logic          full_q;
  logic          empty_q;
  logic          error_q;

  logic          legal;
  logic          misaligned;
  logic [3:0]    al_mask;
  logic [31:0]   al_data;
  logic          store_ok;
  logic          enq;
  logic          deq;
  entry_t        head_entry;

  // Store alignment and legality check.
  always_comb begin
    legal      = 1'b1;
    misaligned = 1'b0;
    al_mask    = 4'b0000;
    al_data    = 32'h0;
    unique case (bus.store_type)
      3'b000: begin
        al_mask = 4'b0001 << bus.store_addr[1:0];
        al_data = {4{bus.store_data[7:0]}};
      end
      3'b001: begin
        misaligned = bus.store_addr[0];
        al_mask    = 4'b0011 << bus.store_addr[1:0];
        al_data    = {2{bus.store_data[15:0]}};
      end
      3'b010: begin
        misaligned = |bus.store_addr[1:0];
        al_mask    = 4'b1111;
        al_data    = bus.store_data;
      end
      default: legal = 1'b0;
    endcase
  end

  assign store_ok   = legal & ~misaligned;
  // Full blocks acceptance for the whole cycle, even if the head drains now.
  assign enq        = bus.store_valid & ~full_q & store_ok;
  assign deq        = ~empty_q & bus.mem_wr_ready;
  assign count_next = count_q + CW'(enq) - CW'(deq);

  // Pointers, occupancy flags and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      error_q <= 1'b0;
    end else begin
      head_q  <= head_q + AW'(deq);
      tail_q  <= tail_q + AW'(enq);
      count_q <= count_next;
      full_q  <= (count_next == CW'(DEPTH));
      empty_q <= (count_next == '0);
      error_q <= bus.store_valid & ~store_ok;
    end
  end

  // Entry storage; validity is implied by head/count, so no reset needed.
  always_ff @(posedge clk) begin
    if (enq) begin
      entries[tail_q] <= {bus.store_addr[31:2], al_data, al_mask};
    end
  end

  assign head_entry       = entries[head_q];

  assign bus.store_accept = enq;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.count        = count_q;
  assign bus.store_error  = error_q;
  assign bus.mem_wr_valid = ~empty_q;
  assign bus.mem_wr_addr  = empty_q ? 32'h0 : {head_entry.waddr, 2'b00};
  assign bus.mem_wr_data  = empty_q ? 32'h0 : head_entry.data;
  assign bus.mem_wr_mask  = empty_q ? 4'h0  : head_entry.mask;

`ifdef STORE_FWD_EN
  logic [AW-1:0] fwd_idx;
  logic [31:0]   fwd_data_c;
  logic [3:0]    fwd_mask_c;

  // Walk oldest to youngest so the youngest matching store owns each lane.
  always_comb begin
    fwd_idx    = '0;
    fwd_data_c = 32'h0;
    fwd_mask_c = 4'h0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + AW'(k);
      if ((CW'(k) < count_q) && (entries[fwd_idx].waddr == bus.fwd_addr[31:2])) begin
        for (int lane = 0; lane < 4; lane++) begin
          if (entries[fwd_idx].mask[lane]) begin
            fwd_data_c[8*lane +: 8] = entries[fwd_idx].data[8*lane +: 8];
            fwd_mask_c[lane]        = 1'b1;
          end
        end
      end
    end
  end

  assign bus.fwd_data = fwd_data_c;
  assign bus.fwd_mask = fwd_mask_c;
  assign bus.fwd_hit  = |fwd_mask_c;
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed steps plus random
// traffic checked against a queue-based reference model.
module tb_store_write_buffer;
  localparam int unsigned DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [29:0] wa;
    logic [31:0] d;
    logic [3:0]  m;
  } ent_t;

  ent_t mq[$];
  bit   exp_err = 1'b0;

  store_write_buffer_if #(.DEPTH(DEPTH)) bus ();
  store_write_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference alignment from the store rules, using plain arithmetic.
  task automatic model_align(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                             output bit ok, output ent_t e);
    int lane;
    lane = int'(a % 4);
    e.wa = a[31:2];
    e.d  = 32'h0;
    e.m  = 4'h0;
    ok   = 1'b0;
    case (t)
      3'd0: begin ok = 1'b1;         e.m = 4'(1 << lane); e.d = 32'(d[7:0])  * 32'h01010101; end
      3'd1: begin ok = (lane % 2 == 0); e.m = 4'(3 << lane); e.d = 32'(d[15:0]) * 32'h00010001; end
      3'd2: begin ok = (lane == 0);  e.m = 4'hF;          e.d = d; end
      default: ok = 1'b0;
    endcase
  endtask

  task automatic drive(input bit v, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] d, input bit r);
    bus.store_valid  = v;
    bus.store_type   = t;
    bus.store_addr   = a;
    bus.store_data   = d;
    bus.mem_wr_ready = r;
  endtask

  task automatic check_state(input string p);
    bit ne;
    ne = (mq.size() > 0);
    chk({p, ".count"}, 32'(bus.count), 32'(mq.size()));
    chk({p, ".empty"}, 32'(bus.empty), 32'(!ne));
    chk({p, ".full"},  32'(bus.full),  32'(mq.size() == DEPTH));
    chk({p, ".valid"}, 32'(bus.mem_wr_valid), 32'(ne));
    chk({p, ".addr"},  bus.mem_wr_addr, ne ? {mq[0].wa, 2'b00} : 32'h0);
    chk({p, ".data"},  bus.mem_wr_data, ne ? mq[0].d : 32'h0);
    chk({p, ".mask"},  32'(bus.mem_wr_mask), ne ? 32'(mq[0].m) : 32'h0);
    chk({p, ".err"},   32'(bus.store_error), 32'(exp_err));
  endtask

  // One clock: check combinational outputs, take the edge, update model, check state.
  task automatic cycle(input string p);
    bit   ok, acc, deq, err_n;
    ent_t e;
`ifdef STORE_FWD_EN
    logic [31:0] fd;
    logic [3:0]  fm;
`endif
    #1;
    model_align(bus.store_type, bus.store_addr, bus.store_data, ok, e);
    acc   = bus.store_valid && ok && (mq.size() < DEPTH);
    deq   = (mq.size() > 0) && bus.mem_wr_ready;
    err_n = bus.store_valid && !ok;
    chk({p, ".accept"}, 32'(bus.store_accept), 32'(acc));
`ifdef STORE_FWD_EN
    fd = 32'h0;
    fm = 4'h0;
    foreach (mq[j]) begin
      if (mq[j].wa == bus.fwd_addr[31:2]) begin
        for (int lane = 0; lane < 4; lane++) begin
          if (mq[j].m[lane]) begin
            fd[8*lane +: 8] = mq[j].d[8*lane +: 8];
            fm[lane] = 1'b1;
          end
        end
      end
    end
    chk({p, ".fwd_mask"}, 32'(bus.fwd_mask), 32'(fm));
    chk({p, ".fwd_data"}, bus.fwd_data, fd);
    chk({p, ".fwd_hit"},  32'(bus.fwd_hit), 32'(|fm));
`endif
    @(posedge clk);
    #1;
    if (deq) void'(mq.pop_front());
    if (acc) mq.push_back(e);
    exp_err = err_n;
    check_state(p);
  endtask

  initial begin
    logic [2:0] rt;
    int         r;
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
`ifdef STORE_FWD_EN
    bus.fwd_addr = 32'h0;
`endif
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
`ifdef STORE_FWD_EN
    chk("reset.fwd_hit",  32'(bus.fwd_hit), 32'h0);
    chk("reset.fwd_mask", 32'(bus.fwd_mask), 32'h0);
`endif
    rst_n = 1'b1;

    // sb 0xAB to 0x1003.
    drive(1'b1, 3'd0, 32'h0000_1003, 32'h0000_00AB, 1'b0);
    cycle("sb");
    chk("sb.valid_c", 32'(bus.mem_wr_valid), 32'h1);
    chk("sb.addr_c",  bus.mem_wr_addr, 32'h0000_1000);
    chk("sb.mask_c",  32'(bus.mem_wr_mask), 32'h8);
    chk("sb.data_c",  bus.mem_wr_data, 32'hABAB_ABAB);
    chk("sb.count_c", 32'(bus.count), 32'h1);
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    cycle("sb_drain");

    // Fill with ready low, fifth store blocked, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd2, 32'h10 + 32'(4 * i), $urandom, 1'b0);
      cycle("fill");
    end
    chk("fill.full_c", 32'(bus.full), 32'h1);
    drive(1'b1, 3'd2, 32'h20, 32'hDEAD_BEEF, 1'b0);
    cycle("fifth");
    chk("fifth.hold_addr", bus.mem_wr_addr, 32'h10);
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("drain.order", bus.mem_wr_addr, 32'h10 + 32'(4 * i));
      cycle("drain");
    end
    chk("drain.empty_c", 32'(bus.empty), 32'h1);

    // Misaligned and illegal stores are dropped with an error pulse.
    drive(1'b1, 3'd1, 32'h0000_2001, 32'h1234, 1'b1);
    cycle("sh_mis");
    chk("sh_mis.err_c", 32'(bus.store_error), 32'h1);
    drive(1'b1, 3'd3, 32'h0000_3000, 32'h1234, 1'b1);
    cycle("illegal");
    chk("illegal.err_c", 32'(bus.store_error), 32'h1);
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    cycle("err_clear");
    chk("err_clear.err_c", 32'(bus.store_error), 32'h0);

    // Count 2, simultaneous enqueue and dequeue.
    drive(1'b1, 3'd2, 32'h100, 32'h1, 1'b0);
    cycle("c2a");
    drive(1'b1, 3'd2, 32'h104, 32'h2, 1'b0);
    cycle("c2b");
    drive(1'b1, 3'd2, 32'h108, 32'h3, 1'b1);
    cycle("simul");
    chk("simul.count_c", 32'(bus.count), 32'h2);

    // Random traffic, pointers wrapping many times.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      rt = (r < 6) ? 3'd0 : (r < 12) ? 3'd1 : (r < 18) ? 3'd2 : 3'(r - 15);
      drive($urandom_range(0, 9) < 7, rt, 32'h40 + 32'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 9) < 5);
`ifdef STORE_FWD_EN
      bus.fwd_addr = 32'h40 + 32'($urandom_range(0, 15));
`endif
      cycle("rand");
    end

    // Drain, queue three entries, then reset between edges.
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    repeat (DEPTH + 1) cycle("pre_rst");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd2, 32'h200 + 32'(4 * i), $urandom, 1'b0);
      cycle("q3");
    end
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.valid", 32'(bus.mem_wr_valid), 32'h0);
    chk("async_rst.count", 32'(bus.count), 32'h0);
    mq.delete();
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state("in_rst");
    rst_n = 1'b1;
    repeat (3) cycle("post_rst");

`ifdef STORE_FWD_EN
    // Forwarding: youngest byte wins, other word misses.
    drive(1'b1, 3'd2, 32'h40, 32'h1122_3344, 1'b0);
    cycle("fwd_sw");
    drive(1'b1, 3'd0, 32'h41, 32'h0000_0055, 1'b0);
    cycle("fwd_sb");
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    bus.fwd_addr = 32'h40;
    #1;
    chk("fwd40.mask", 32'(bus.fwd_mask), 32'hF);
    chk("fwd40.data", bus.fwd_data, 32'h1122_5544);
    chk("fwd40.hit",  32'(bus.fwd_hit), 32'h1);
    bus.fwd_addr = 32'h44;
    #1;
    chk("fwd44.hit",  32'(bus.fwd_hit), 32'h0);
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    repeat (3) cycle("fwd_drain");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
